// File: rtl/cnn_result_streamer_if.sv
// Result stream handshake between cnn_result_streamer (master) and its consumer (slave).
// One element per transfer; a transfer happens on a cycle with out_valid and out_ready both high.
interface cnn_result_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = 6
);
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
    logic [IDX_W-1:0]      out_index;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/cnn_result_streamer.sv
// Captures one flat CNN conv2 result frame on a rising in_valid and streams it out element by element.
// While streaming it tracks the running max and publishes the argmax once the frame has been sent.
module cnn_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BYTES  = 48,
    parameter int IDX_W      = 6
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH*NUM_BYTES-1:0] in_data,
    input  logic                            in_valid,
    output logic                            in_taken,
    cnn_result_streamer_if.master           stream,
    output logic                            busy,
    output logic                            overrun,
    output logic [IDX_W-1:0]                argmax_idx,
    output logic [DATA_WIDTH-1:0]           argmax_val,
    output logic                            argmax_valid
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] buf_q [NUM_BYTES];
    logic                  in_valid_q;
    logic [DATA_WIDTH-1:0] max_val;
    logic [IDX_W-1:0]      max_idx;
    logic                  frame_evt;
    logic                  xfer;
    logic                  take_elem;
    logic [IDX_W-1:0]      next_idx;
    logic [DATA_WIDTH-1:0] upd_val;
    logic [IDX_W-1:0]      upd_idx;

    assign frame_evt = in_valid && !in_valid_q;
    assign xfer      = (state == STREAM) && stream.out_valid && stream.out_ready;
    assign next_idx  = stream.out_index + IDX_W'(1);

    // Max including the element being transferred now; strict '>' keeps the lowest index on ties.
    always_comb begin
        take_elem = (stream.out_index == '0) || (stream.out_data > max_val);
        upd_val   = max_val;
        upd_idx   = max_idx;
        if (take_elem) begin
            upd_val = stream.out_data;
            upd_idx = stream.out_index;
        end
    end

    // Frame buffer carries no reset; its contents only matter after a capture.
    always_ff @(posedge clk) begin
        if (state == IDLE && frame_evt) begin
            for (int unsigned k = 0; k < NUM_BYTES; k++) begin
                buf_q[k] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            in_valid_q       <= 1'b0;
            in_taken         <= 1'b0;
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            stream.out_data  <= '0;
            stream.out_index <= '0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
            max_val          <= '0;
            max_idx          <= '0;
            argmax_idx       <= '0;
            argmax_val       <= '0;
            argmax_valid     <= 1'b0;
        end else begin
            in_valid_q   <= in_valid;
            in_taken     <= 1'b0;
            argmax_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_evt) begin
                        // Element 0 bypasses the buffer so it is presented the cycle after capture.
                        state            <= STREAM;
                        in_taken         <= 1'b1;
                        busy             <= 1'b1;
                        stream.out_valid <= 1'b1;
                        stream.out_index <= '0;
                        stream.out_data  <= in_data[DATA_WIDTH-1:0];
                        stream.out_last  <= (NUM_BYTES == 1);
                        max_val          <= '0;
                        max_idx          <= '0;
                    end
                end
                STREAM: begin
                    if (frame_evt) overrun <= 1'b1;
                    if (xfer) begin
                        max_val <= upd_val;
                        max_idx <= upd_idx;
                        if (stream.out_last) begin
                            state            <= DONE;
                            stream.out_valid <= 1'b0;
                            stream.out_last  <= 1'b0;
                            argmax_val       <= upd_val;
                            argmax_idx       <= upd_idx;
                            argmax_valid     <= 1'b1;
                        end else begin
                            stream.out_index <= next_idx;
                            stream.out_data  <= buf_q[next_idx];
                            stream.out_last  <= (next_idx == LAST_IDX);
                        end
                    end
                end
                DONE: begin
                    if (frame_evt) overrun <= 1'b1;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnn_result_streamer.sv
// Directed sequence with randomized frames and backpressure, checked against a frame-level reference
// (expected element list plus first-max search) held in the bench.
module tb_cnn_result_streamer;
    localparam int DW = 8;
    localparam int N  = 48;
    localparam int IW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW*N-1:0] in_data;
    logic            in_valid;
    logic            in_taken;
    logic            busy;
    logic            overrun;
    logic [IW-1:0]   argmax_idx;
    logic [DW-1:0]   argmax_val;
    logic            argmax_valid;

    int n_tests   = 0;
    int n_fail    = 0;
    int taken_cnt = 0;
    logic [DW-1:0] ref_q [N];

    cnn_result_streamer_if #(.DATA_WIDTH(DW), .IDX_W(IW)) s_if ();

    cnn_result_streamer #(
        .DATA_WIDTH(DW),
        .NUM_BYTES (N),
        .IDX_W     (IW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_taken    (in_taken),
        .stream      (s_if),
        .busy        (busy),
        .overrun     (overrun),
        .argmax_idx  (argmax_idx),
        .argmax_val  (argmax_val),
        .argmax_valid(argmax_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (in_taken === 1'b1) taken_cnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_frame();
        for (int k = 0; k < N; k++) in_data[k*DW +: DW] = ref_q[k];
    endtask

    task automatic rand_frame(input int hi);
        for (int k = 0; k < N; k++) ref_q[k] = DW'($urandom_range(0, hi));
    endtask

    function automatic void ref_argmax(output int idx, output int val);
        idx = 0;
        val = int'(ref_q[0]);
        for (int k = 1; k < N; k++) begin
            if (int'(ref_q[k]) > val) begin
                idx = k;
                val = int'(ref_q[k]);
            end
        end
    endfunction

    // Entered at the negedge right after capture; returns at the negedge after the DONE cycle.
    task automatic stream_body(input int mode, input int glitch_at, input bit done_evt);
        int            exp_idx = 0;
        int            cyc     = 0;
        int            gl      = 0;
        bit            done    = 0;
        bit            stalled = 0;
        bit            r;
        logic [DW-1:0] prev_d  = '0;
        int            ai, av;
        ref_argmax(ai, av);
        while (!done && cyc < 400) begin
            chk("out_valid", s_if.out_valid, 1);
            chk("busy_stream", busy, 1);
            chk("out_index", s_if.out_index, exp_idx);
            chk("out_data", s_if.out_data, ref_q[exp_idx]);
            chk("out_last", s_if.out_last, (exp_idx == N - 1));
            if (stalled) chk("stall_data", s_if.out_data, prev_d);
            if (cyc == 1) chk("in_taken_pulse", in_taken, 0);
            if (gl == 1) begin
                in_valid = 1'b0;
                gl = 2;
            end
            if (gl == 0 && exp_idx == glitch_at) begin
                in_valid = 1'b1;
                gl = 1;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            s_if.out_ready = r;
            if (r) begin
                if (exp_idx == N - 1) done = 1;
                exp_idx++;
            end
            stalled = !r;
            prev_d  = s_if.out_data;
            @(negedge clk);
            cyc++;
        end
        chk("frame_completed", done, 1);
        if (mode == 0) chk("xfer_cycles", cyc, N);
        s_if.out_ready = 1'b0;
        chk("done_out_valid", s_if.out_valid, 0);
        chk("done_out_last", s_if.out_last, 0);
        chk("done_busy", busy, 1);
        chk("argmax_valid", argmax_valid, 1);
        chk("argmax_idx", argmax_idx, ai);
        chk("argmax_val", argmax_val, av);
        if (done_evt) in_valid = 1'b1;
        @(negedge clk);
        chk("argmax_valid_pulse", argmax_valid, 0);
        chk("idle_busy", busy, 0);
        chk("argmax_idx_hold", argmax_idx, ai);
        chk("argmax_val_hold", argmax_val, av);
    endtask

    task automatic run_frame(input int mode, input int glitch_at, input bit hold, input bit done_evt);
        pack_frame();
        in_valid = 1'b1;
        @(negedge clk);
        chk("in_taken", in_taken, 1);
        if (!hold) in_valid = 1'b0;
        for (int k = 0; k < N; k++) in_data[k*DW +: DW] = DW'($urandom);
        stream_body(mode, glitch_at, done_evt);
    endtask

    initial begin
        int base;
        rst            = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        s_if.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", s_if.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_in_taken", in_taken, 0);
        chk("rst_argmax_valid", argmax_valid, 0);
        chk("rst_out_index", s_if.out_index, 0);
        rst = 1'b1;
        @(negedge clk);

        for (int k = 0; k < N; k++) ref_q[k] = DW'(k + 1);
        run_frame(0, -1, 0, 0);
        run_frame(1, -1, 0, 0);

        for (int k = 0; k < N; k++) ref_q[k] = 8'h00;
        ref_q[5]  = 8'hF0;
        ref_q[30] = 8'hF0;
        run_frame(2, -1, 0, 0);
        chk("tie_idx", argmax_idx, 5);

        rand_frame(255);
        base = taken_cnt;
        run_frame(0, -1, 1, 0);
        repeat (150) @(negedge clk);
        chk("hold_busy", busy, 0);
        chk("hold_overrun", overrun, 0);
        chk("hold_captures", taken_cnt - base, 1);
        in_valid = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 3; t++) begin
            rand_frame(t == 0 ? 3 : 255);
            run_frame(2, -1, 0, 0);
        end

        rand_frame(255);
        base = taken_cnt;
        run_frame(0, 10, 0, 0);
        chk("overrun_set", overrun, 1);
        repeat (5) @(negedge clk);
        chk("overrun_sticky", overrun, 1);
        chk("overrun_no_frame", taken_cnt - base, 1);
        chk("overrun_idle", busy, 0);

        rand_frame(255);
        pack_frame();
        in_valid       = 1'b1;
        s_if.out_ready = 1'b1;
        @(negedge clk);
        repeat (20) @(negedge clk);
        chk("pre_rst_idx", s_if.out_index, 20);
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", s_if.out_valid, 0);
        chk("mrst_out_last", s_if.out_last, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_overrun", overrun, 0);
        chk("mrst_argmax_valid", argmax_valid, 0);
        chk("mrst_out_data", s_if.out_data, 0);
        chk("mrst_out_index", s_if.out_index, 0);
        chk("mrst_argmax_idx", argmax_idx, 0);
        chk("mrst_argmax_val", argmax_val, 0);
        rand_frame(255);
        pack_frame();
        rst = 1'b1;
        @(negedge clk);
        chk("rel_in_taken", in_taken, 1);
        for (int k = 0; k < N; k++) in_data[k*DW +: DW] = DW'($urandom);
        stream_body(0, -1, 0);
        in_valid = 1'b0;
        @(negedge clk);

        rand_frame(255);
        base = taken_cnt;
        run_frame(0, -1, 0, 1);
        chk("done_evt_overrun", overrun, 1);
        @(negedge clk);
        chk("done_evt_no_capture", in_taken, 0);
        chk("done_evt_idle", busy, 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_evt_captures", taken_cnt - base, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cnn_result_streamer.md
CNN_RESULT_STREAMER -- requirements
Module: cnn_result_streamer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width in bits of one result element.
REQ-002 Parameter NUM_BYTES, default 48, number of result elements per frame (6 groups x 2 kernels x 2x2 conv2 outputs).
REQ-003 Parameter IDX_W, default 6, width of index outputs; SHALL satisfy 2^IDX_W >= NUM_BYTES.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 in_data  input  DATA_WIDTH*NUM_BYTES  flat conv2 result; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-007 in_valid  input  1  result-ready level from the CNN core (may stay high for many cycles).
REQ-008 in_taken  output  1  one-cycle pulse: frame captured.
REQ-009 out_data  output  DATA_WIDTH  current streamed element.
REQ-010 out_valid  output  1  out_data valid.
REQ-011 out_ready  input  1  downstream accepts element.
REQ-012 out_last  output  1  high with final element of the frame.
REQ-013 out_index  output  IDX_W  index of the element on out_data.
REQ-014 busy  output  1  high while not in IDLE.
REQ-015 overrun  output  1  sticky: new frame arrived while busy.
REQ-016 argmax_idx  output  IDX_W  index of the largest element of the last frame.
REQ-017 argmax_val  output  DATA_WIDTH  value of that element.
REQ-018 argmax_valid  output  1  one-cycle pulse: argmax outputs updated.

Function
REQ-019 FSM states IDLE, STREAM, DONE; reset state IDLE.
REQ-020 in_valid SHALL be registered every cycle; a frame event is in_valid=1 while the previous registered sample was 0.
REQ-021 IDLE + frame event: in_data copied into internal buffer, element counter cleared to 0, running max cleared (value 0, index 0), in_taken=1 in the next cycle, next state STREAM.
REQ-022 in_valid held high after capture SHALL NOT produce a second capture; a new frame needs in_valid to go low for at least one cycle.
REQ-023 STREAM: out_valid=1, out_data=buffer[counter], out_index=counter, out_last=(counter==NUM_BYTES-1).
REQ-024 Transfer occurs on a cycle with out_valid=1 and out_ready=1; counter increments by 1 per transfer; with out_ready low, out_data/out_index/out_last SHALL hold stable.
REQ-025 First element valid the cycle after capture (capture-to-first-valid latency 1 cycle); full frame with out_ready held high takes NUM_BYTES cycles.
REQ-026 Running max updated on each transfer: unsigned compare, replace only when element > current max (ties keep the lowest index); element 0 always loads the max.
REQ-027 Transfer with out_last=1: next state DONE; counter SHALL NOT wrap to 0 while in STREAM.
REQ-028 DONE lasts exactly one cycle: out_valid=0, argmax_idx/argmax_val loaded with the running max, argmax_valid=1; next state IDLE.
REQ-029 argmax_idx/argmax_val hold their value until the next DONE.
REQ-030 Frame event in STREAM or DONE: data ignored, buffer unchanged, overrun set to 1 and held until reset.
REQ-031 A frame event in the same cycle the FSM returns to IDLE (the DONE cycle) SHALL count as overrun, not capture.
REQ-032 busy=1 in STREAM and DONE, 0 in IDLE.
REQ-033 in_data is sampled only at capture; later changes SHALL NOT affect the streamed frame.

Reset
REQ-034 rst=0 at a rising edge: state IDLE; in_taken, out_valid, out_last, busy, overrun, argmax_valid = 0; out_data, out_index, argmax_idx, argmax_val = 0; registered in_valid = 0; buffer contents don't care.
REQ-035 Reset mid-STREAM aborts the frame with no out_last and no argmax_valid; if in_valid is still high at release, it SHALL be captured as a new frame on the first cycle after release.

Verification
REQ-036 Element k = k+1 (1..48), out_ready=1 -> in_taken one cycle after event; 48 transfers in 48 cycles, out_data 1..48, out_last only on index 47; argmax_idx=47, argmax_val=48, argmax_valid one cycle after last transfer.
REQ-037 Same frame, out_ready toggled 1,0,1,0 -> out_data stable while ready=0; 48 transfers total; no dropped or duplicated index.
REQ-038 Elements all 0x00 except index 5 and index 30 = 0xF0 -> argmax_idx=5, argmax_val=0xF0 (tie keeps lowest).
REQ-039 in_valid held high 200 cycles -> exactly one capture and one frame; overrun stays 0.
REQ-040 Second rising edge of in_valid at element 10 of a stream -> overrun=1 and held; current frame completes unchanged; no second frame.
REQ-041 rst=0 at element 20, in_valid high at release -> outputs cleared per REQ-034; new frame captured on the first cycle after release and streamed from index 0.
